// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one ram1024x32 between four requesters. One owner at a
// time, chosen round-robin. A dead RELEASE cycle separates successive owners.
// An owner that holds the RAM too long while others wait can be preempted.
//
// Handshake (req/gnt): a requester raises req[i] and holds it for its whole
// transaction. gnt is registered and one-hot. In every cycle where gnt[i] is
// high, requester i's address, data and write enable drive the RAM port
// combinationally. Read data returns on m_q one cycle later. A requester drops
// req[i] only after its last read data has been captured. An edge that sees
// req[owner] low ends the grant. Losing gnt without dropping req means the
// owner was preempted; it keeps req high to be re-granted later.
module ram_arbiter #(
  parameter int MAX_HOLD = 1023
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [39:0]  m_address,
  input  logic [127:0] m_data,
  input  logic [3:0]   m_wren,
  output logic [3:0]   gnt,
  output logic [31:0]  m_q,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         preempt,
  output logic [9:0]   ram_address,
  output logic         ram_clock,
  output logic [31:0]  ram_data,
  output logic         ram_wren,
  input  logic [31:0]  ram_q
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWNED   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Hold count at which a waiting requester forces the owner off the RAM.
  localparam logic [31:0] HOLD_LIM = (MAX_HOLD == 0) ? 32'd0 : 32'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        preempt_q, preempt_d;

  logic        arb_found;
  logic [1:0]  arb_winner;
  logic [1:0]  cand;
  logic        others_pending;
  logic        hold_expired;

  // Round-robin search: start just above the last owner, so the last owner
  // comes last.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = owner_q;
    cand       = owner_q;
    for (int k = 1; k <= 4; k++) begin
      cand = owner_q + 2'(k);
      if (!arb_found && req[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  assign others_pending = (req & ~gnt_q) != 4'b0000;
  assign hold_expired   = (MAX_HOLD != 0) && (32'(hold_cnt_q) >= HOLD_LIM);

  // Next-state logic: grant, release, or preempt.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    case (state_q)
      S_OWNED: begin
        if (!req[owner_q]) begin
          // A voluntary release wins over a timeout at the same edge.
          state_d = S_RELEASE;
          gnt_d   = 4'b0000;
        end else if (hold_expired && others_pending) begin
          state_d   = S_RELEASE;
          gnt_d     = 4'b0000;
          preempt_d = 1'b1;
        end else if (hold_cnt_q != 16'hFFFF) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      S_IDLE, S_RELEASE: begin
        if (arb_found) begin
          state_d    = S_OWNED;
          owner_d    = arb_winner;
          gnt_d      = 4'b0001 << arb_winner;
          hold_cnt_d = 16'd0;
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State register. After reset, owner 3 makes requester 0 the first to win.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 4'b0000;
      owner_q    <= 2'd3;
      hold_cnt_q <= 16'd0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  // RAM port mux. Only the owner reaches the RAM. The bus is zero otherwise.
  // Writes are blocked whenever reset is high.
  always_comb begin
    ram_address = 10'd0;
    ram_data    = 32'd0;
    ram_wren    = 1'b0;
    if (state_q == S_OWNED) begin
      ram_address = m_address[owner_q * 10 +: 10];
      ram_data    = m_data[owner_q * 32 +: 32];
      ram_wren    = m_wren[owner_q] & ~reset;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = (state_q == S_OWNED);
  assign preempt   = preempt_q;
  assign m_q       = ram_q;
  assign ram_clock = clock;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules.
module tb_ram_arbiter;

  localparam int TB_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [39:0]  m_address;
  logic [127:0] m_data;
  logic [3:0]   m_wren;
  logic [3:0]   gnt;
  logic [31:0]  m_q;
  logic [1:0]   owner;
  logic         busy;
  logic         preempt;
  logic [9:0]   ram_address;
  logic         ram_clock;
  logic [31:0]  ram_data;
  logic         ram_wren;
  logic [31:0]  ram_q;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.MAX_HOLD(TB_HOLD)) dut (
    .clock(clock), .reset(reset), .req(req), .m_address(m_address),
    .m_data(m_data), .m_wren(m_wren), .gnt(gnt), .m_q(m_q), .owner(owner),
    .busy(busy), .preempt(preempt), .ram_address(ram_address),
    .ram_clock(ram_clock), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Behavioural RAM: synchronous write, one-cycle registered read.
  logic [31:0] mem [0:1023];
  always @(posedge ram_clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // ---------------- reference model ----------------
  // m_state: 0 = nobody owns, 1 = owned, 2 = dead turnaround cycle.
  int m_state, m_owner, m_hold;
  bit m_pre;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    bit others;
    int w;
    if (reset) begin
      m_state = 0; m_owner = 3; m_hold = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_state == 1) begin
      others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
      if (!req[m_owner]) m_state = 2;
      else if (m_hold >= TB_HOLD - 1 && others) begin m_state = 2; m_pre = 1; end
      else m_hold++;
    end else begin
      w = pick(req, m_owner);
      if (w >= 0) begin m_state = 1; m_owner = w; m_hold = 0; end
      else m_state = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic advance();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; m_wren = 4'b0000;
    advance();
    advance();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL reset_owner got=%0d exp=3", owner); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    total++; if (ram_wren !== 1'b0 || ram_address !== 10'd0) begin bad++; $display("FAIL reset_bus wren=%b addr=%h exp 0/000", ram_wren, ram_address); end
    advance();
  endtask

  task automatic test_write_read();
    do_reset();
    req = 4'b0001;
    advance();
    m_wren = 4'b0001; m_address[9:0] = 10'h020; m_data[31:0] = 32'h8000_0000;
    @(negedge clock);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL wr_wren got=%b exp=1", ram_wren); end
    total++; if (ram_address !== 10'h020) begin bad++; $display("FAIL wr_addr got=%h exp=020", ram_address); end
    total++; if (ram_data !== 32'h8000_0000) begin bad++; $display("FAIL wr_data got=%h exp=80000000", ram_data); end
    advance();
    m_wren = 4'b0000;
    @(negedge clock);
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rd_wren got=%b exp=0", ram_wren); end
    advance();
    @(negedge clock);
    total++; if (m_q !== 32'h8000_0000) begin bad++; $display("FAIL rd_q got=%h exp=80000000", m_q); end
    req = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_q[$];
    logic [3:0] e_gnt;
    int e;
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    m_wren = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      m_address[10*i +: 10] = 10'h100 + 10'(i);
      m_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    req = 4'b1111;
    advance();
    for (int n = 0; n < 5; n++) begin
      e = n % 4;
      e_gnt = exp_q.pop_front();
      for (int c = 1; c <= 3; c++) begin
        if (c == 3) req[e] = 1'b0;
        @(negedge clock);
        total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rr_gnt n=%0d c=%0d got=%b exp=%b", n, c, gnt, e_gnt); end
        total++; if (ram_address !== 10'h100 + 10'(e) || ram_wren !== 1'b1) begin bad++; $display("FAIL rr_bus n=%0d addr=%h wren=%b exp=%h/1", n, ram_address, ram_wren, 10'h100 + 10'(e)); end
        advance();
      end
      if (n < 4) req[e] = 1'b1;
      else req = 4'b0000;
      @(negedge clock);
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_release n=%0d gnt=%b busy=%b exp=0000/0", n, gnt, busy); end
      total++; if (ram_wren !== 1'b0 || ram_address !== 10'd0 || ram_data !== 32'd0) begin bad++; $display("FAIL rr_release_bus n=%0d wren=%b addr=%h data=%h exp zeros", n, ram_wren, ram_address, ram_data); end
      advance();
    end
    m_wren = 4'b0000;
    advance();
  endtask

  task automatic test_preempt();
    logic [3:0] e_gnt;
    logic       e_pre;
    do_reset();
    req = 4'b0100;
    advance();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) req[1] = 1'b1;
      e_gnt = (c <= 8) ? 4'b0100 : (c == 9) ? 4'b0000 : 4'b0010;
      e_pre = (c == 9);
      @(negedge clock);
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL pre_gnt c=%0d got=%b exp=%b", c, gnt, e_gnt); end
      total++; if (preempt !== e_pre) begin bad++; $display("FAIL pre_pulse c=%0d got=%b exp=%b", c, preempt, e_pre); end
      advance();
    end
    req = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_drop_at_timeout();
    do_reset();
    req = 4'b0100;
    advance();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) req[1] = 1'b1;
      if (c == 8) req[2] = 1'b0;
      @(negedge clock);
      if (c == 9) begin
        total++; if (gnt !== 4'b0000 || preempt !== 1'b0) begin bad++; $display("FAIL drop_pre gnt=%b pre=%b exp=0000/0", gnt, preempt); end
      end
      if (c == 10) begin
        total++; if (gnt !== 4'b0010 || owner !== 2'd1) begin bad++; $display("FAIL drop_next gnt=%b owner=%0d exp=0010/1", gnt, owner); end
      end
      advance();
    end
    req = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_sole_owner();
    do_reset();
    req = 4'b1000;
    advance();
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      total++; if (gnt !== 4'b1000 || preempt !== 1'b0) begin bad++; $display("FAIL sole c=%0d gnt=%b pre=%b exp=1000/0", c, gnt, preempt); end
      advance();
    end
    req = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req = 4'b0010;
    advance();
    m_wren = 4'b0010; m_address[19:10] = 10'h155; m_data[63:32] = 32'h1234_5678;
    @(negedge clock);
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL midrst_pre_wren got=%b exp=1", ram_wren); end
    advance();
    reset = 1'b1;
    @(negedge clock);
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL midrst_wren got=%b exp=0", ram_wren); end
    advance();
    reset = 1'b0;
    @(negedge clock);
    total++; if (gnt !== 4'b0000 || owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state gnt=%b owner=%0d busy=%b exp=0000/3/0", gnt, owner, busy); end
    req = 4'b0000; m_wren = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_nonowner_ignored();
    do_reset();
    req = 4'b0001;
    m_wren = 4'b0101;
    m_address[9:0] = 10'h011;   m_data[31:0]  = 32'hAAAA_0001;
    m_address[29:20] = 10'h3F0; m_data[95:64] = 32'hBBBB_0002;
    advance();
    @(negedge clock);
    total++; if (ram_address !== 10'h011 || ram_data !== 32'hAAAA_0001 || ram_wren !== 1'b1) begin bad++; $display("FAIL nonown_a addr=%h data=%h wren=%b exp=011/aaaa0001/1", ram_address, ram_data, ram_wren); end
    advance();
    m_wren = 4'b0100;
    @(negedge clock);
    total++; if (ram_address !== 10'h011 || ram_wren !== 1'b0) begin bad++; $display("FAIL nonown_b addr=%h wren=%b exp=011/0", ram_address, ram_wren); end
    req = 4'b0000; m_wren = 4'b0000;
    advance();
    advance();
  endtask

  task automatic test_random();
    int len [4];
    int served [4];
    logic [3:0]  e_gnt;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic        e_wren;
    do_reset();
    for (int i = 0; i < 4; i++) begin len[i] = 0; served[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (m_state == 1 && m_owner == i) begin
            served[i]++;
            if (served[i] >= len[i]) req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1; len[i] = $urandom_range(1, 14); served[i] = 0;
        end
      end
      m_address = {8'($urandom), $urandom()};
      m_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_wren    = 4'($urandom);
      e_gnt  = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
      e_addr = (m_state == 1) ? m_address[10*m_owner +: 10] : 10'd0;
      e_data = (m_state == 1) ? m_data[32*m_owner +: 32] : 32'd0;
      e_wren = (m_state == 1) && m_wren[m_owner] && !reset;
      @(negedge clock);
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      total++; if (owner !== 2'(m_owner) || busy !== (m_state == 1)) begin bad++; $display("FAIL rnd_owner cyc=%0d owner=%0d busy=%b exp=%0d/%0d", cyc, owner, busy, m_owner, m_state == 1); end
      total++; if (preempt !== m_pre) begin bad++; $display("FAIL rnd_preempt cyc=%0d got=%b exp=%b", cyc, preempt, m_pre); end
      total++; if (ram_address !== e_addr || ram_data !== e_data || ram_wren !== e_wren) begin bad++; $display("FAIL rnd_bus cyc=%0d addr=%h data=%h wren=%b exp=%h/%h/%b", cyc, ram_address, ram_data, ram_wren, e_addr, e_data, e_wren); end
      advance();
    end
    reset = 1'b0; req = 4'b0000; m_wren = 4'b0000;
    advance();
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; req = 4'b0000; m_wren = 4'b0000;
    m_address = 40'd0; m_data = 128'd0;
    m_state = 0; m_owner = 3; m_hold = 0; m_pre = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_preempt();
    test_drop_at_timeout();
    test_sole_owner();
    test_reset_mid_write();
    test_nonowner_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single ram1024x32 instance between up to four RAM-using sub-modules: card allocation, add-card, remove-nth-card and split-list.
- Grants one requester at a time using round-robin priority.
- Muxes the granted requester's address, data and write enable onto the RAM port, and broadcasts ram_q back to all requesters.
- Inserts a one-cycle bus turnaround between owners, and can preempt an owner that holds the RAM too long while others wait.

Parameters:
- MAX_HOLD, 1023: cycles an owner may hold the grant while another requester is pending before it is preempted. 0 disables preemption.

Ports:
- clock  in  1  system clock; RAM clock is derived from it.
- reset  in  1  synchronous, active-high.
- req  in  4  per-requester request; held high for the whole transaction.
- m_address  in  40  packed requester addresses; requester i uses bits [10i+9:10i].
- m_data  in  128  packed write data; requester i uses bits [32i+31:32i].
- m_wren  in  4  per-requester write enable.
- gnt  out  4  one-hot grant, registered.
- m_q  out  32  RAM read data, broadcast to all requesters (equals ram_q).
- owner  out  2  index of the current or last owner.
- busy  out  1  high when in state OWNED.
- preempt  out  1  one-cycle pulse when a grant is revoked by the hold timeout.
- ram_address  out  10  to RAM.
- ram_clock  out  1  equals clock.
- ram_data  out  32  to RAM.
- ram_wren  out  1  to RAM.
- ram_q  in  32  from RAM.

Behaviour:
States: IDLE, OWNED, RELEASE (2-bit encoding).

Reset (edge with reset=1):
- state=IDLE, gnt=0, owner=3 (so requester 0 has top priority first), hold_cnt=0, preempt=0.
- ram_wren is combinationally gated by ~reset, so no write occurs during any cycle with reset high, including mid-transaction.

Arbitration (at an edge in IDLE or RELEASE with req!=0):
- Winner is the first set bit of req, searching upward from owner+1 mod 4.
- Next state OWNED; owner=winner; gnt=1<<winner; hold_cnt=0.
- Grant latency is 1 cycle: req rises at edge t, gnt is high after edge t+1.
- In IDLE with req==0, stay in IDLE.

OWNED:
- ram_address, ram_data and ram_wren follow the owner's slice combinationally (same cycle).
- hold_cnt increments each cycle and saturates at 16'hFFFF.
- At an edge where req[owner]==0: go to RELEASE, gnt=0.
- At an edge where MAX_HOLD!=0, hold_cnt>=MAX_HOLD-1, and another requester is pending (req & ~gnt != 0): go to RELEASE, gnt=0, preempt=1 for one cycle.
- If both conditions hold at the same edge, the release is treated as normal and preempt stays 0.
- With no other requester pending, the owner keeps the grant indefinitely.

RELEASE:
- Lasts exactly one cycle: gnt=0, ram_wren=0, ram_address=0, ram_data=0.
- At its closing edge, arbitrate as in IDLE, or go to IDLE if req==0.
- A preempted owner that keeps req high is eligible again, but at lowest priority.

Outside OWNED:
- ram_address=0, ram_data=0, ram_wren=0.

Read data:
- RAM read latency is one cycle.
- m_q is valid for an address presented in OWNED on the following cycle.
- A requester must not drop req until its last read data has been captured.

Other rules:
- Unused requesters tie req low.
- A m_wren from a non-owner is ignored.
- Simultaneous requests are resolved purely by round-robin order.
- A requester that drops req and re-raises it in the same RELEASE cycle competes normally.

Test Plan:
1. Reset, then req=0001 -> gnt=0001 after 1 edge; m_wren[0]=1, m_address[9:0]=10'h020, m_data[31:0]=32'h80000000 -> RAM word 0x020 written; read back on m_q one cycle later.
2. req=1111 held, each owner drops req after 3 OWNED cycles -> grant order 0,1,2,3,0 with exactly one RELEASE cycle (gnt=0, ram_wren=0) between owners.
3. MAX_HOLD=8, requester 2 holds req, requester 1 raises req at cycle 2 of ownership -> after 8 OWNED cycles gnt drops, preempt pulses once, then gnt=0010 next.
4. MAX_HOLD=8, only requester 3 requesting for 50 cycles -> gnt stays 1000, preempt never asserts.
5. Requester 1 writing (m_wren[1]=1), reset asserted for one cycle -> ram_wren=0 in that cycle; next cycle state IDLE, gnt=0, owner=3.
6. Requester 0 owns the RAM while requester 2 drives m_wren[2]=1 with a different address -> ram_address and ram_data match requester 0 only; no write from requester 2.
